// File: rtl/accel_host_pkg.sv
// Shared constants and FSM state encoding for the byte-sum accelerator host.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package accel_host_pkg;

    // Front-end data width; the host's default memory/accelerator width follows it.
    localparam int FE_DATA_W  = 32;
    localparam int DATA_W_DEF = FE_DATA_W;
    localparam int ADDR_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;
    localparam int ACC_W_DEF  = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_ACC_GO  = 3'd3,
        ST_ACC_REL = 3'd4,
        ST_FINISH  = 3'd5
    } state_e;

endpackage

// File: rtl/accel_host_acc.sv
// Job accumulator: adds one accelerator result per enable, with sticky wrap flag.
// Latency: sum_o/ovf_o update on the clock edge after add_en_i or clr_i.
// Backpressure: none; every enabled add is absorbed in one cycle.
module accel_host_acc #(
    parameter int ACC_W = 32,
    parameter int IN_W  = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             add_en_i,
    input  logic [IN_W-1:0]  add_val_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             ovf_o
);

    // Wide enough that any carry out of the ACC_W result is visible.
    localparam int SW = ((ACC_W > IN_W) ? ACC_W : IN_W) + 1;

    logic [ACC_W-1:0] sum_q, sum_d;
    logic             ovf_q, ovf_d;
    logic [SW-1:0]    full_sum;

    assign full_sum = SW'(sum_q) + SW'(add_val_i);

    // Clear wins over add; any bits above ACC_W mean the result wrapped.
    always_comb begin
        sum_d = sum_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            sum_d = '0;
            ovf_d = 1'b0;
        end else if (add_en_i) begin
            sum_d = full_sum[ACC_W-1:0];
            ovf_d = ovf_q | (|full_sum[SW-1:ACC_W]);
        end
    end

    // Accumulator registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            ovf_q <= ovf_d;
        end
    end

    assign sum_o = sum_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/accel_host.sv
// Fetches N words over iob, runs each through the byte-sum accelerator, accumulates.
// Latency: per word >= 6 cycles with zero-wait memory (RD_REQ 1, ACC_GO >= 3, ACC_REL >= 2).
// Backpressure: holds iob request until iob_ready_i; holds acc_start_o until acc_done_i, then waits for done to fall.
import accel_host_pkg::*;

module accel_host #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              job_start_i,
    input  logic [ADDR_W-1:0] job_addr_i,
    input  logic [CNT_W-1:0]  job_cnt_i,
    output logic              busy_o,
    output logic              job_done_o,
    output logic [ACC_W-1:0]  result_o,
    output logic              ovf_o,
    output logic              iob_valid_o,
    output logic [ADDR_W-1:0] iob_addr_o,
    input  logic              iob_ready_i,
    input  logic              iob_rvalid_i,
    input  logic [DATA_W-1:0] iob_rdata_i,
    output logic              acc_start_o,
    output logic [DATA_W-1:0] acc_data_o,
    input  logic              acc_done_i,
    input  logic [DATA_W-1:0] acc_result_i
);

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              acc_clr, acc_add;

    // State, address, remaining count and operand word registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic; job parameters are only sampled in IDLE so a start while busy is ignored.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        acc_clr = 1'b0;
        acc_add = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (job_start_i) begin
                    addr_d  = job_addr_i;
                    cnt_d   = job_cnt_i;
                    acc_clr = 1'b1;
                    state_d = (job_cnt_i == '0) ? ST_FINISH : ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                if (iob_ready_i) begin
                    if (iob_rvalid_i) begin
                        data_d  = iob_rdata_i;
                        state_d = ST_ACC_GO;
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (iob_rvalid_i) begin
                    data_d  = iob_rdata_i;
                    state_d = ST_ACC_GO;
                end
            end
            ST_ACC_GO: begin
                // Leaving on the first done cycle guarantees a single add per word.
                if (acc_done_i) begin
                    acc_add = 1'b1;
                    state_d = ST_ACC_REL;
                end
            end
            ST_ACC_REL: begin
                // Start may only be raised again once done has dropped.
                if (!acc_done_i) begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    addr_d  = addr_q + ADDR_STEP;
                    state_d = (cnt_q == CNT_W'(1)) ? ST_FINISH : ST_RD_REQ;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    accel_host_acc #(
        .ACC_W (ACC_W),
        .IN_W  (DATA_W)
    ) u_acc (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clr_i     (acc_clr),
        .add_en_i  (acc_add),
        .add_val_i (acc_result_i),
        .sum_o     (result_o),
        .ovf_o     (ovf_o)
    );

    assign busy_o      = (state_q != ST_IDLE);
    assign job_done_o  = (state_q == ST_FINISH);
    assign iob_valid_o = (state_q == ST_RD_REQ);
    assign iob_addr_o  = addr_q;
    assign acc_start_o = (state_q == ST_ACC_GO);
    assign acc_data_o  = data_q;

endmodule

// File: tb/tb_accel_host.sv
module tb_accel_host;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        job_start;
    logic [31:0] job_addr;
    logic [15:0] job_cnt;

    logic        busy, job_done, ovf, iob_valid, acc_start;
    logic [31:0] result, iob_addr, acc_data;
    logic        iob_ready, iob_rvalid;
    logic [31:0] iob_rdata;
    logic        acc_done = 1'b0;
    logic [31:0] acc_res  = '0;

    logic        busy8, done8, ovf8, iob_valid8, acc_start8;
    logic [7:0]  result8;
    logic [31:0] iob_addr8, acc_data8;

    always #5 clk = ~clk;

    accel_host u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .job_start_i(job_start), .job_addr_i(job_addr),
        .job_cnt_i(job_cnt), .busy_o(busy), .job_done_o(job_done), .result_o(result),
        .ovf_o(ovf), .iob_valid_o(iob_valid), .iob_addr_o(iob_addr), .iob_ready_i(iob_ready),
        .iob_rvalid_i(iob_rvalid), .iob_rdata_i(iob_rdata), .acc_start_o(acc_start),
        .acc_data_o(acc_data), .acc_done_i(acc_done), .acc_result_i(acc_res)
    );

    // Narrow-accumulator copy driven by the same stimulus; only result/ovf differ.
    accel_host #(.ACC_W(8)) u_dut8 (
        .clk_i(clk), .rst_n_i(rst_n), .job_start_i(job_start), .job_addr_i(job_addr),
        .job_cnt_i(job_cnt), .busy_o(busy8), .job_done_o(done8), .result_o(result8),
        .ovf_o(ovf8), .iob_valid_o(iob_valid8), .iob_addr_o(iob_addr8), .iob_ready_i(iob_ready),
        .iob_rvalid_i(iob_rvalid), .iob_rdata_i(iob_rdata), .acc_start_o(acc_start8),
        .acc_data_o(acc_data8), .acc_done_i(acc_done), .acc_result_i(acc_res)
    );

    // ---------------- memory model ----------------
    logic [31:0] mem [256];
    int          ready_lat = 0;
    int          rd_lat    = 0;
    logic        pend      = 1'b0;
    int          pend_ctr  = 0;
    int          wait_ctr  = 0;
    logic [31:0] pend_data = '0;

    always_comb begin
        iob_ready  = iob_valid && (wait_ctr >= ready_lat);
        iob_rvalid = 1'b0;
        iob_rdata  = '0;
        if (iob_ready && rd_lat == 0) begin
            iob_rvalid = 1'b1;
            iob_rdata  = mem[iob_addr[9:2]];
        end else if (pend && pend_ctr >= rd_lat) begin
            iob_rvalid = 1'b1;
            iob_rdata  = pend_data;
        end
    end

    always @(posedge clk) begin
        if (iob_valid && !iob_ready) wait_ctr <= wait_ctr + 1;
        else                         wait_ctr <= 0;
        if (iob_ready && rd_lat != 0) begin
            pend      <= 1'b1;
            pend_ctr  <= 1;
            pend_data <= mem[iob_addr[9:2]];
        end else if (pend) begin
            if (iob_rvalid) pend <= 1'b0;
            else            pend_ctr <= pend_ctr + 1;
        end
    end

    // ---------------- accelerator model ----------------
    function automatic logic [9:0] byte_sum(input logic [31:0] w);
        return 10'(w[7:0]) + 10'(w[15:8]) + 10'(w[23:16]) + 10'(w[31:24]);
    endfunction

    int acc_ctr = 0;

    // done two cycles after start rises, held while start is high plus one extra cycle.
    always @(posedge clk) begin
        if (acc_start && !acc_done) begin
            if (acc_ctr >= 1) begin
                acc_done <= 1'b1;
                acc_res  <= {22'd0, byte_sum(acc_data)};
            end
            acc_ctr <= acc_ctr + 1;
        end else begin
            acc_ctr <= 0;
            if (!acc_start) acc_done <= 1'b0;
        end
    end

    // ---------------- scoreboard and checks ----------------
    typedef struct {
        logic [31:0] r32;
        logic        o32;
        logic [7:0]  r8;
        logic        o8;
    } exp_t;

    logic [31:0] exp_addr_q [$];
    exp_t        exp_res_q  [$];

    int          checks = 0;
    int          errors = 0;
    int          done_seen, valid_seen, start_seen;
    logic        prev_wait  = 1'b0;
    logic        prev_start = 1'b0;
    logic [31:0] prev_addr  = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample everything at the falling edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (iob_valid) valid_seen++;
        if (prev_wait) check("iob_addr_hold", 64'(iob_addr), 64'(prev_addr));
        if (iob_valid && iob_ready) begin
            check("iob_req_expected", 64'(exp_addr_q.size() != 0), 64'(1));
            if (exp_addr_q.size() != 0) check("iob_addr", 64'(iob_addr), 64'(exp_addr_q.pop_front()));
        end
        prev_wait = iob_valid && !iob_ready;
        prev_addr = iob_addr;
        if (acc_start && !prev_start) begin
            start_seen++;
            check("start_while_done", 64'(acc_done), 64'(0));
        end
        prev_start = acc_start;
        if (job_done) begin
            done_seen++;
            check("done_expected", 64'(exp_res_q.size() != 0), 64'(1));
            if (exp_res_q.size() != 0) begin
                e = exp_res_q.pop_front();
                check("result32", 64'(result), 64'(e.r32));
                check("ovf32", 64'(ovf), 64'(e.o32));
                check("result8", 64'(result8), 64'(e.r8));
                check("ovf8", 64'(ovf8), 64'(e.o8));
            end
        end
    endtask

    // Queue expected addresses and the independently summed result, then pulse start.
    task automatic launch(input logic [31:0] addr, input logic [15:0] cnt);
        longint      total;
        logic [31:0] a;
        exp_t        e;
        total = 0;
        a     = addr;
        for (int i = 0; i < int'(cnt); i++) begin
            exp_addr_q.push_back(a);
            total += longint'(byte_sum(mem[a[9:2]]));
            a += 32'd4;
        end
        e.r32 = total[31:0];
        e.o32 = (total > 64'hFFFF_FFFF);
        e.r8  = total[7:0];
        e.o8  = (total > 255);
        exp_res_q.push_back(e);
        done_seen  = 0;
        valid_seen = 0;
        start_seen = 0;
        job_start  = 1'b1;
        job_addr   = addr;
        job_cnt    = cnt;
        step();
        job_start  = 1'b0;
        check("busy_after_start", 64'(busy), 64'(1));
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done_seen == 0 && n < budget) begin
            step();
            n++;
        end
        check({tag, "_done_timeout"}, 64'(done_seen != 0), 64'(1));
        step();
        check({tag, "_done_pulses"}, 64'(done_seen), 64'(1));
        check({tag, "_busy_low"}, 64'(busy), 64'(0));
        check({tag, "_done_low"}, 64'(job_done), 64'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(job_done), 64'(0));
        check({tag, "_result"}, 64'(result), 64'(0));
        check({tag, "_ovf"}, 64'(ovf), 64'(0));
        check({tag, "_iob_valid"}, 64'(iob_valid), 64'(0));
        check({tag, "_iob_addr"}, 64'(iob_addr), 64'(0));
        check({tag, "_acc_start"}, 64'(acc_start), 64'(0));
        check({tag, "_acc_data"}, 64'(acc_data), 64'(0));
        check({tag, "_result8"}, 64'(result8), 64'(0));
        check({tag, "_ovf8"}, 64'(ovf8), 64'(0));
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst_n     = 1'b0;
        job_start = 1'b0;
        job_addr  = '0;
        job_cnt   = '0;
        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Single word, zero-wait memory.
        mem[8'h40] = 32'h0102_0304;
        launch(32'h100, 16'd1);
        wait_done("one_word", 200);
        check("one_word_starts", 64'(start_seen), 64'(1));

        // Three words with read data returned 4 cycles after acceptance.
        mem[8'h40] = 32'hFFFF_FFFF;
        mem[8'h41] = 32'h0000_0000;
        mem[8'h42] = 32'h8080_8080;
        rd_lat = 4;
        launch(32'h100, 16'd3);
        wait_done("three_word", 400);
        rd_lat = 0;

        // Zero-length job: completion pulse on the first cycle after capture, no traffic.
        launch(32'h100, 16'd0);
        check("cnt0_done_latency", 64'(done_seen), 64'(1));
        wait_done("cnt0", 10);
        check("cnt0_no_iob", 64'(valid_seen), 64'(0));
        check("cnt0_no_start", 64'(start_seen), 64'(0));
        check("cnt0_result", 64'(result), 64'(0));

        // Two words of 200 each, with a slow request handshake.
        mem[8'h60] = 32'h3232_3232;
        mem[8'h61] = 32'h3232_3232;
        ready_lat = 2;
        launch(32'h180, 16'd2);
        wait_done("wrap8", 400);
        ready_lat = 0;

        // Address wraps past the top of the address space.
        mem[8'hFF] = 32'h0000_0001;
        mem[8'h00] = 32'h0000_0002;
        launch(32'hFFFF_FFFC, 16'd2);
        wait_done("addr_wrap", 400);

        // Start pulse while busy must not disturb the running job.
        mem[8'h40] = 32'h0102_0304;
        mem[8'h41] = 32'h0101_0101;
        launch(32'h100, 16'd2);
        repeat (3) step();
        job_start = 1'b1;
        job_addr  = 32'h200;
        job_cnt   = 16'd5;
        step();
        job_start = 1'b0;
        wait_done("ignored_start", 400);
        valid_seen = 0;
        repeat (5) step();
        check("idle_no_iob", 64'(valid_seen), 64'(0));

        // Reset during ACC_GO abandons the job silently.
        mem[8'h40] = 32'h0101_0101;
        launch(32'h100, 16'd2);
        n = 0;
        while (!acc_start && n < 50) begin
            step();
            n++;
        end
        check("reached_acc_go", 64'(acc_start), 64'(1));
        rst_n = 1'b0;
        step();
        check_all_zero("midjob_reset");
        check("midjob_no_done", 64'(done_seen), 64'(0));
        rst_n = 1'b1;
        exp_addr_q.delete();
        exp_res_q.delete();
        repeat (4) step();
        launch(32'h100, 16'd1);
        wait_done("after_reset", 200);

        check("addr_queue_empty", 64'(exp_addr_q.size()), 64'(0));
        check("result_queue_empty", 64'(exp_res_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
